// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback controller and its load-tag FIFO.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_IEU  = 2'd1,
        WB_LOAD = 2'd2,
        WB_PC   = 2'd3
    } wb_kind_e;

    localparam logic [4:0] REG_ZERO          = 5'd0;
    localparam int         DEFAULT_MAX_LOADS = 2;

    // Kinds whose result is written straight from the E stage.
    function automatic logic is_pipe_kind(input wb_kind_e kind);
        return (kind == WB_IEU) || (kind == WB_PC);
    endfunction

endpackage

// File: rtl/load_tag_fifo.sv
// In-order FIFO of destination tags for outstanding loads; DEPTH must be a power of two.
module load_tag_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_LOADS,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] tag_in,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= tag_in;
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller and load scoreboard for the register-file write port.
// Optional macro WB_CTRL_ERR_EN adds a sticky err output for orphan LSU responses.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_LOADS = DEFAULT_MAX_LOADS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  wb_kind_e        issue_kind,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    output logic            stall,
    input  logic            lsu_rsp_valid,
    output logic            lsu_rsp_ready,
    input  logic [XLEN-1:0] lsu_rsp_data,
    output logic [4:0]      rd_addr,
    output logic            wb_ieu,
    output logic            wb_lsu,
    output logic            wb_pc,
    output logic [XLEN-1:0] lsu_data
`ifdef WB_CTRL_ERR_EN
    ,
    output logic            err
`endif
);

    logic       e_valid;
    wb_kind_e   e_kind;
    logic [4:0] e_rd;

    logic [31:1] pend;
    logic [31:0] pend_vec;

    logic       hold_valid;
    logic [4:0] hold_rd;

    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_head;

    logic pipe_wb;
    logic drain;
    logic hold_wr;
    logic rsp_accept;
    logic issue_ok;
    logic load_accept;
    logic rs1_haz;
    logic rs2_haz;
    logic waw_haz;

    // x0 occupies bit 0 and is never set, so it can never look pending.
    assign pend_vec = {pend, 1'b0};

    assign pipe_wb       = e_valid && is_pipe_kind(e_kind) && (e_rd != REG_ZERO);
    assign drain         = hold_valid && !pipe_wb;
    assign hold_wr       = drain && (hold_rd != REG_ZERO);
    assign lsu_rsp_ready = !hold_valid || drain;
    assign rsp_accept    = lsu_rsp_valid && lsu_rsp_ready && !fifo_empty;
    assign issue_ok      = issue_valid && !stall;
    assign load_accept   = issue_ok && (issue_kind == WB_LOAD);

    // The register file reads on the write edge, so an E-stage result costs one bubble.
    assign rs1_haz = issue_use_rs1 && (issue_rs1 != REG_ZERO) &&
                     (pend_vec[issue_rs1] || (pipe_wb && issue_rs1 == e_rd) ||
                      (hold_valid && issue_rs1 == hold_rd));
    assign rs2_haz = issue_use_rs2 && (issue_rs2 != REG_ZERO) &&
                     (pend_vec[issue_rs2] || (pipe_wb && issue_rs2 == e_rd) ||
                      (hold_valid && issue_rs2 == hold_rd));
    assign waw_haz = (issue_rd != REG_ZERO) && pend_vec[issue_rd];

    assign stall = issue_valid &&
                   (rs1_haz || rs2_haz || waw_haz || (issue_kind == WB_LOAD && fifo_full));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wb_ieu  = 1'b0;
        wb_pc   = 1'b0;
        wb_lsu  = 1'b0;
        rd_addr = REG_ZERO;
        if (pipe_wb) begin
            wb_ieu  = (e_kind == WB_IEU);
            wb_pc   = (e_kind == WB_PC);
            rd_addr = e_rd;
        end else if (hold_wr) begin
            wb_lsu  = 1'b1;
            rd_addr = hold_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid <= 1'b0;
            e_kind  <= WB_NONE;
            e_rd    <= REG_ZERO;
        end else begin
            e_valid <= issue_ok;
            if (issue_ok) begin
                e_kind <= issue_kind;
                e_rd   <= issue_rd;
            end
        end
    end

    // Set and clear never target the same register: WAW holds the second load back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (load_accept && issue_rd == 5'(r))
                    pend[r] <= 1'b1;
                else if (hold_wr && hold_rd == 5'(r))
                    pend[r] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_rd    <= REG_ZERO;
            lsu_data   <= '0;
        end else if (rsp_accept) begin
            hold_valid <= 1'b1;
            hold_rd    <= fifo_head;
            lsu_data   <= lsu_rsp_data;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

`ifdef WB_CTRL_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (lsu_rsp_valid && fifo_empty)
            err <= 1'b1;
    end
`endif

    load_tag_fifo #(
        .DEPTH (MAX_LOADS),
        .W     (5)
    ) u_tags (
        .clk    (clk),
        .reset  (reset),
        .push   (load_accept),
        .tag_in (issue_rd),
        .pop    (rsp_accept),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed vector table, reset corner case, randomized run against a queue model.
module tb_wb_ctrl;
    import wb_pkg::*;

    localparam int XLEN = 32;
    localparam int ML   = 2;
    localparam logic [1:0] KN = 2'd0, KI = 2'd1, KL = 2'd2, KP = 2'd3;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid;
    wb_kind_e        issue_kind;
    logic [4:0]      issue_rd, issue_rs1, issue_rs2;
    logic            issue_use_rs1, issue_use_rs2;
    logic            stall;
    logic            lsu_rsp_valid;
    logic            lsu_rsp_ready;
    logic [XLEN-1:0] lsu_rsp_data;
    logic [4:0]      rd_addr;
    logic            wb_ieu, wb_lsu, wb_pc;
    logic [XLEN-1:0] lsu_data;
`ifdef WB_CTRL_ERR_EN
    logic            err;
`endif

    always #5 clk = ~clk;

    wb_ctrl #(.XLEN(XLEN), .MAX_LOADS(ML)) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_kind    (issue_kind),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .stall         (stall),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rsp_data  (lsu_rsp_data),
        .rd_addr       (rd_addr),
        .wb_ieu        (wb_ieu),
        .wb_lsu        (wb_lsu),
        .wb_pc         (wb_pc),
        .lsu_data      (lsu_data)
`ifdef WB_CTRL_ERR_EN
        ,
        .err           (err)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [1:0]  kind;
        logic [4:0]  rd, rs1, rs2;
        logic        u1, u2, rv;
        logic [31:0] rdata;
        logic        x_stall, x_ready, x_ieu, x_lsu, x_pc;
        logic [4:0]  x_addr;
        logic [31:0] x_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic iv, input logic [1:0] kind,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic rv, input logic [31:0] rdata,
                               input logic s, input logic rdy, input logic ieu, input logic lsu,
                               input logic pc, input logic [4:0] addr, input logic [31:0] data);
        vec_t t;
        t.iv = iv; t.kind = kind; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.u1 = u1; t.u2 = u2; t.rv = rv; t.rdata = rdata;
        t.x_stall = s; t.x_ready = rdy; t.x_ieu = ieu; t.x_lsu = lsu; t.x_pc = pc;
        t.x_addr = addr; t.x_data = data;
        return t;
    endfunction

    task automatic drive(input logic iv, input logic [1:0] kind, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic rv, input logic [31:0] rdata);
        issue_valid   = iv;
        issue_kind    = wb_kind_e'(kind);
        issue_rd      = rd;
        issue_rs1     = rs1;
        issue_rs2     = rs2;
        issue_use_rs1 = u1;
        issue_use_rs2 = u2;
        lsu_rsp_valid = rv;
        lsu_rsp_data  = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic s, input logic rdy, input logic ieu,
                              input logic lsu, input logic pc, input logic [4:0] addr,
                              input logic [31:0] data);
        check({tag, ".stall"},    32'(stall),         32'(s));
        check({tag, ".ready"},    32'(lsu_rsp_ready), 32'(rdy));
        check({tag, ".wb_ieu"},   32'(wb_ieu),        32'(ieu));
        check({tag, ".wb_lsu"},   32'(wb_lsu),        32'(lsu));
        check({tag, ".wb_pc"},    32'(wb_pc),         32'(pc));
        check({tag, ".rd_addr"},  32'(rd_addr),       32'(addr));
        check({tag, ".lsu_data"}, lsu_data,           data);
    endtask

    // Reference model: outstanding loads as a tag queue, the held response, and the last issue.
    logic [4:0]  m_q[$];
    bit          m_hv;
    logic [4:0]  m_hrd;
    logic [31:0] m_data;
    bit          m_ev;
    logic [1:0]  m_ek;
    logic [4:0]  m_erd;
    bit          m_err;

    function automatic bit m_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
        return m_hv && (m_hrd == r);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hv = 0; m_hrd = 0; m_data = 0; m_ev = 0; m_ek = KN; m_erd = 0; m_err = 0;
    endtask

    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h11111111;
    localparam logic [31:0] D2 = 32'h22222222;

    initial begin
        reset = 1'b1;
        drive(0, KN, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // iv kind rd rs1 rs2 u1 u2 rv rdata | stall ready ieu lsu pc addr data
        // IEU rd5 then a reader of x5; PC rd14 then a reader of x14.
        vecs.push_back(v(1, KI,  5, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0));
        vecs.push_back(v(1, KI,  6, 5,  0, 1, 0, 0, 0,  1, 1, 1, 0, 0,  5, 0));
        vecs.push_back(v(1, KI,  6, 5,  0, 1, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0));
        vecs.push_back(v(1, KP, 14, 0,  0, 0, 0, 0, 0,  0, 1, 1, 0, 0,  6, 0));
        vecs.push_back(v(1, KI,  1, 0, 14, 0, 1, 0, 0,  1, 1, 0, 0, 1, 14, 0));
        vecs.push_back(v(1, KI,  1, 0, 14, 0, 1, 0, 0,  0, 1, 0, 0, 0,  0, 0));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 0, 0,  0, 1, 1, 0, 0,  1, 0));
        // LOAD rd7, response four cycles later; readers of x7 held until after wb_lsu.
        vecs.push_back(v(1, KL,  7, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0));
        vecs.push_back(v(1, KI,  8, 7,  0, 1, 0, 0, 0,  1, 1, 0, 0, 0,  0, 0));
        vecs.push_back(v(1, KI,  8, 0,  7, 0, 1, 0, 0,  1, 1, 0, 0, 0,  0, 0));
        vecs.push_back(v(1, KI,  8, 7,  7, 1, 1, 0, 0,  1, 1, 0, 0, 0,  0, 0));
        vecs.push_back(v(1, KI,  8, 7,  0, 1, 0, 1, D0, 1, 1, 0, 0, 0,  0, 0));
        vecs.push_back(v(1, KI,  8, 7,  0, 1, 0, 0, 0,  1, 1, 0, 1, 0,  7, D0));
        vecs.push_back(v(1, KI,  8, 7,  0, 1, 0, 0, 0,  0, 1, 0, 0, 0,  0, D0));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 0, 0,  0, 1, 1, 0, 0,  8, D0));
        // Response collides with IEU writeback; a second response waits on ready.
        vecs.push_back(v(1, KL,  9, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, D0));
        vecs.push_back(v(1, KL, 11, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, D0));
        vecs.push_back(v(1, KI,  3, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, D0));
        vecs.push_back(v(1, KI, 10, 0,  0, 0, 0, 1, D1, 0, 1, 1, 0, 0,  3, D0));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 1, D2, 0, 0, 1, 0, 0, 10, D1));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 1, D2, 0, 1, 0, 1, 0,  9, D1));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 11, D2));
        // Three loads against two tags; writes land in issue order.
        vecs.push_back(v(1, KL,  1, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, D2));
        vecs.push_back(v(1, KL,  2, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, D2));
        vecs.push_back(v(1, KL,  4, 0,  0, 0, 0, 1, 32'hA1, 1, 1, 0, 0, 0, 0, D2));
        vecs.push_back(v(1, KL,  4, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1, 0,  1, 32'hA1));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 1, 32'hA2, 0, 1, 0, 0, 0, 0, 32'hA1));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 1, 32'hA4, 0, 1, 0, 1, 0, 2, 32'hA2));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1, 0,  4, 32'hA4));
        // x0 as a load and IEU destination: no strobes, no hazards, tags still in order.
        vecs.push_back(v(1, KL,  0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 32'hA4));
        vecs.push_back(v(1, KI,  0, 0,  0, 1, 1, 0, 0,  0, 1, 0, 0, 0,  0, 32'hA4));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 1, 32'h5, 0, 1, 0, 0, 0, 0, 32'hA4));
        vecs.push_back(v(1, KI, 12, 0,  0, 1, 0, 0, 0,  0, 1, 0, 0, 0,  0, 32'h5));
        vecs.push_back(v(1, KL, 13, 0,  0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 12, 32'h5));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 1, 32'h13, 0, 1, 0, 0, 0, 0, 32'h5));
        vecs.push_back(v(0, KN,  0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 13, 32'h13));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, 1, 0, 0, 0, 0, 0);
`ifdef WB_CTRL_ERR_EN
        check("reset.err", 32'(err), 32'd0);
`endif
        next_cycle();
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].u1, vecs[i].u2, vecs[i].rv, vecs[i].rdata);
            @(negedge clk);
            check_outs($sformatf("v%0d", i), vecs[i].x_stall, vecs[i].x_ready, vecs[i].x_ieu,
                       vecs[i].x_lsu, vecs[i].x_pc, vecs[i].x_addr, vecs[i].x_data);
            next_cycle();
        end

        // Reset in the middle of a cycle with two loads outstanding.
        drive(1, KL, 1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, KL, 2, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, KI, 5, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("prerst.stall", 32'(stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_outs("midrst", 0, 1, 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("postrst.stall", 32'(stall), 32'd1 - 32'd1);
        next_cycle();
        drive(0, KN, 0, 0, 0, 0, 0, 1, 32'h77);
        @(negedge clk);
        check("orphan.ready", 32'(lsu_rsp_ready), 32'd1);
        check("orphan.wb_ieu", 32'(wb_ieu), 32'd1);
        check("orphan.rd_addr", 32'(rd_addr), 32'd5);
        next_cycle();
        drive(1, KL, 2, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("drop.wb_lsu", 32'(wb_lsu), 32'd0);
        check("drop.rd_addr", 32'(rd_addr), 32'd0);
        check("drop.lsu_data", lsu_data, 32'd0);
        check("drop.stall", 32'(stall), 32'd0);
`ifdef WB_CTRL_ERR_EN
        check("drop.err", 32'(err), 32'd1);
`endif
        next_cycle();

        // Randomized run against the queue model.
        drive(0, KN, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic        iv, u1, u2, rv;
            logic [1:0]  kind;
            logic [4:0]  rd, rs1, rs2, x_addr;
            logic [31:0] rdata;
            bit          pipe, h1, h2, x_stall, x_ready, x_lsu;
            iv    = ($urandom_range(0, 3) != 0);
            kind  = 2'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 7));
            rs1   = 5'($urandom_range(0, 7));
            rs2   = 5'($urandom_range(0, 7));
            u1    = 1'($urandom_range(0, 1));
            u2    = 1'($urandom_range(0, 1));
            rv    = ($urandom_range(0, 2) == 0);
            rdata = $urandom;
            drive(iv, kind, rd, rs1, rs2, u1, u2, rv, rdata);

            pipe    = m_ev && (m_ek == KI || m_ek == KP) && (m_erd != 0);
            h1      = u1 && (rs1 != 0) && (m_pending(rs1) || (pipe && m_erd == rs1));
            h2      = u2 && (rs2 != 0) && (m_pending(rs2) || (pipe && m_erd == rs2));
            x_stall = iv && (h1 || h2 || m_pending(rd) || (kind == KL && m_q.size() == ML));
            x_ready = !(m_hv && pipe);
            x_lsu   = m_hv && !pipe && (m_hrd != 0);
            x_addr  = pipe ? m_erd : (x_lsu ? m_hrd : 5'd0);

            @(negedge clk);
            check_outs($sformatf("rnd%0d", c), x_stall, x_ready, pipe && m_ek == KI, x_lsu,
                       pipe && m_ek == KP, x_addr, m_data);
`ifdef WB_CTRL_ERR_EN
            check($sformatf("rnd%0d.err", c), 32'(err), 32'(m_err));
`endif
            if (rv && m_q.size() == 0) m_err = 1;
            if (rv && x_ready && m_q.size() > 0) begin
                m_hrd  = m_q.pop_front();
                m_hv   = 1;
                m_data = rdata;
            end else if (m_hv && !pipe) begin
                m_hv = 0;
            end
            if (iv && !x_stall) begin
                m_ev  = 1;
                m_ek  = kind;
                m_erd = rd;
                if (kind == KL) m_q.push_back(rd);
            end else begin
                m_ev = 0;
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback controller and load scoreboard that drives the register file's write side: `rd_addr`, one-hot `wb_ieu`/`wb_lsu`/`wb_pc`, `lsu_data`.
- Drives the read-side `stall`.
- Tracks in-order outstanding loads by destination tag.
- Arbitrates the single write port between pipeline writeback and variable-latency LSU responses.
- Stalls issue on RAW/WAW hazards against pending writes.

Parameters:
- XLEN, 32, data width
- MAX_LOADS, 2, outstanding load tags; power of two, 2..8

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_kind  in  2  wb_kind_e: NONE / IEU / LOAD / PC
- issue_rd  in  5  destination register
- issue_rs1  in  5  source 1
- issue_rs2  in  5  source 2
- issue_use_rs1  in  1  rs1 is read
- issue_use_rs2  in  1  rs2 is read
- stall  out  1  hold decode and register-file reads
- lsu_rsp_valid  in  1  load data valid
- lsu_rsp_ready  out  1  response accepted when valid & ready
- lsu_rsp_data  in  XLEN  load data
- rd_addr  out  5  register-file write address
- wb_ieu  out  1  write the ALU result
- wb_lsu  out  1  write `lsu_data`
- wb_pc  out  1  write the link PC
- lsu_data  out  XLEN  held load data

Behaviour:
- Reset (async, active-high) clears:
  - E-stage valid
  - scoreboard `pend[31:1]`
  - tag FIFO
  - hold register
- Reset values of outputs:
  - `wb_*` = 0, `rd_addr` = 0, `lsu_data` = 0
  - `stall` = 0, `lsu_rsp_ready` = 1
- Reset mid-operation discards all outstanding loads.

E stage:
- On `issue_valid && !stall`, register `e_valid`, `e_kind`, `e_rd`; otherwise `e_valid` <= 0.

Pipeline writeback (combinational from E stage, one cycle after issue):
- `e_valid`, kind IEU, `e_rd` != 0: `wb_ieu` = 1, `rd_addr` = `e_rd`.
- Kind PC: same, but `wb_pc` = 1.
- This is `pipe_wb`. It always has priority over load writeback.

Load issue:
- Accepted LOAD pushes `issue_rd` into the tag FIFO, including x0.
- Sets `pend[rd]` if rd != 0.

LSU response:
- `lsu_rsp_ready` = `!hold_valid || drain`.
- On accept: pop the FIFO, capture data into `lsu_data` and the tag into `hold_rd`, set `hold_valid`.

Drain:
- `drain` = `hold_valid && !pipe_wb`.
- When draining with `hold_rd` != 0: `wb_lsu` = 1, `rd_addr` = `hold_rd`, `pend[hold_rd]` cleared at the same clock edge.
- When draining with `hold_rd` = 0: no write strobe.
- Drain and new accept in the same cycle are legal; the new response replaces the hold contents.

Write strobes:
- At most one `wb_*` per cycle.
- Never asserted for rd = 0.

Stall (combinational) when `issue_valid` and any of:
- a used rs has `pend` set;
- a used rs equals `e_rd` with `e_valid`, kind IEU/PC, `e_rd` != 0 (register file reads ram at the write edge, so 1-cycle RAW bubble);
- a used rs equals `hold_rd` with `hold_valid`, `hold_rd` != 0;
- `issue_rd` != 0 and `pend[issue_rd]` (WAW);
- kind LOAD and FIFO full.

x0 is never pending and never hazards.

Simultaneous scoreboard set/clear on the same register cannot occur, because WAW stalls it.

Optional Feature:
- Macro: WB_CTRL_ERR_EN
- Enabled:
  - adds output `err` (1 bit, sticky until reset);
  - `err` sets on `lsu_rsp_valid` with FIFO empty;
  - the orphan response is consumed and dropped.
- Disabled:
  - no `err` port;
  - an orphan response is consumed with ready = 1 and dropped; FIFO and scoreboard are unchanged.

Decomposition:
- Package `wb_pkg`:
  - `wb_kind_e` enum (NONE=0, IEU=1, LOAD=2, PC=3)
  - `REG_ZERO` constant
  - default `MAX_LOADS`
- Sub-module `load_tag_fifo`: 5-bit-wide, MAX_LOADS-deep synchronous FIFO.
  - push, pop, full, empty, head;
  - async reset;
  - simultaneous push+pop keeps occupancy constant;
  - pointer wrap-around at MAX_LOADS.

Test Plan:
- IEU rd=5, next issue reads rs1=5 → cycle+1: `wb_ieu` = 1, `rd_addr` = 5; reader stalled exactly 1 cycle.
- LOAD rd=7, response 4 cycles later with data 0xDEADBEEF → `stall` high for any rs=7 until the cycle after `wb_lsu` (`rd_addr` = 7, `lsu_data` = 0xDEADBEEF).
- Response arrives in the same cycle as IEU writeback rd=3 → `wb_ieu` rd=3 first; `wb_lsu` next cycle; `lsu_rsp_ready` = 0 for a second response meanwhile.
- Issue 3 loads (rd=1,2,4) with MAX_LOADS=2 → third stalls until first response accepted; responses write rd 1,2,4 in order.
- LOAD rd=0, then IEU rd=0 → no `wb_*` asserted; FIFO pops normally; no stall on rs=0.
- Reset asserted with 2 loads pending → `pend` and FIFO cleared asynchronously; after release, rs=1 issue does not stall. With WB_CTRL_ERR_EN, a following orphan response sets `err` = 1.
